// File: rtl/cache_line_reader.sv
// Read-side sequencer for the byte-register cache data array: walks one line
// byte by byte through one-hot line select / byte select and streams it out.
module cache_line_reader #(
  parameter int unsigned LINE_BYTES = 4,
  parameter int unsigned IDX_BITS   = 3,
  parameter int unsigned BSEL_BITS  = $clog2(LINE_BYTES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [IDX_BITS-1:0]        req_index,
  output logic                       req_ready,
  input  logic                       flush,
  output logic                       rd_en,
  output logic [(1<<IDX_BITS)-1:0]   line_sel,
  output logic [BSEL_BITS-1:0]       byte_sel,
  input  logic [7:0]                 rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned numLines = 1 << IDX_BITS;
  localparam logic [BSEL_BITS-1:0] lastByte = BSEL_BITS'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    Idle,
    Read,
    Send
  } stateType;

  stateType              state;
  logic [IDX_BITS-1:0]   idxQ;
  logic [BSEL_BITS-1:0]  byteCnt;

  function automatic logic [numLines-1:0] lineOneHot(input logic [IDX_BITS-1:0] idx);
    return numLines'(1) << idx;
  endfunction

  assign byte_sel = byteCnt;

  // All control outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= Idle;
      idxQ      <= '0;
      byteCnt   <= '0;
      req_ready <= 1'b1;
      rd_en     <= 1'b0;
      line_sel  <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= Idle;
      req_ready <= 1'b1;
      rd_en     <= 1'b0;
      line_sel  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (req_valid) begin
            state     <= Read;
            idxQ      <= req_index;
            byteCnt   <= '0;
            req_ready <= 1'b0;
            rd_en     <= 1'b1;
            line_sel  <= lineOneHot(req_index);
            busy      <= 1'b1;
          end
        end
        Read: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          out_last  <= (byteCnt == lastByte);
          rd_en     <= 1'b0;
          line_sel  <= '0;
          state     <= Send;
        end
        Send: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last  <= 1'b0;
              state     <= Idle;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              // Last-byte check ends the line, so the counter never wraps.
              byteCnt  <= byteCnt + BSEL_BITS'(1);
              state    <= Read;
              rd_en    <= 1'b1;
              line_sel <= lineOneHot(idxQ);
            end
          end
        end
        default: begin
          state     <= Idle;
          req_ready <= 1'b1;
          rd_en     <= 1'b0;
          line_sel  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_reader.sv
// Bench for cache_line_reader: an array model answers line/byte selects and
// expected byte streams are derived from that array content.
module tb_cache_line_reader;

  localparam int unsigned LB    = 4;
  localparam int unsigned IDXB  = 3;
  localparam int unsigned LINES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_index;
  logic       req_ready;
  logic       flush;
  logic       rd_en;
  logic [7:0] line_sel;
  logic [1:0] byte_sel;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  logic [7:0] mem [LINES][LB];
  int nChecks = 0;
  int nFail   = 0;

  cache_line_reader #(.LINE_BYTES(LB), .IDX_BITS(IDXB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .flush(flush), .rd_en(rd_en), .line_sel(line_sel),
    .byte_sel(byte_sel), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Array model: garbage when not strobed so off-cycle sampling is visible.
  always_comb begin
    rd_data = 8'hEE;
    if (rd_en) begin
      for (int i = 0; i < LINES; i++)
        if (line_sel[i]) rd_data = mem[i][byte_sel];
    end
  end

  function automatic logic [7:0] oneHot(input int idx);
    logic [7:0] v;
    v = 8'h01;
    return v << idx;
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_index = '0; flush = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++;
      if ({req_ready, rd_en, line_sel, byte_sel, out_valid, out_data, out_last, busy} !== 23'h400000) begin
        nFail++;
        $display("FAIL reset_hold: got rdy=%b rd=%b sel=%h bs=%h v=%b d=%h l=%b busy=%b", req_ready, rd_en, line_sel, byte_sel, out_valid, out_data, out_last, busy);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nChecks++;
      if ({req_ready, out_valid, line_sel, out_data, busy} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
        nFail++;
        $display("FAIL reset_idle: got rdy=%b v=%b sel=%h d=%h busy=%b, expected 1 0 00 00 0", req_ready, out_valid, line_sel, out_data, busy);
      end
    end
  endtask

  // Reads one full line from IDLE with exact cycle timing; optional stall on one byte.
  task automatic do_line(input int idx, input int stallByte, input int stallCyc);
    req_valid = 1'b1; req_index = 3'(idx); out_ready = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({rd_en, line_sel, byte_sel, req_ready, busy} !== {1'b1, oneHot(idx), 2'd0, 1'b0, 1'b1}) begin
      nFail++;
      $display("FAIL accept_read line %0d: got rd=%b sel=%h bs=%0d rdy=%b busy=%b, expected sel=%h", idx, rd_en, line_sel, byte_sel, req_ready, busy, oneHot(idx));
    end
    req_valid = 1'b0; req_index = 3'($urandom);
    for (int b = 0; b < LB; b++) begin
      if (b == stallByte) out_ready = 1'b0;
      @(negedge clk);
      nChecks++;
      if ({out_valid, out_data, out_last, rd_en} !== {1'b1, mem[idx][b], (b == LB - 1), 1'b0}) begin
        nFail++;
        $display("FAIL byte line %0d b%0d: got v=%b d=%h l=%b rd=%b, expected v=1 d=%h l=%b rd=0", idx, b, out_valid, out_data, out_last, rd_en, mem[idx][b], (b == LB - 1));
      end
      if (b == stallByte) begin
        for (int s = 1; s < stallCyc; s++) begin
          @(negedge clk);
          nChecks++;
          if ({out_valid, out_data, rd_en} !== {1'b1, mem[idx][b], 1'b0}) begin
            nFail++;
            $display("FAIL stall_hold b%0d s%0d: got v=%b d=%h rd=%b, expected v=1 d=%h rd=0", b, s, out_valid, out_data, rd_en, mem[idx][b]);
          end
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      nChecks++;
      if (b < LB - 1) begin
        if ({rd_en, line_sel, byte_sel, out_valid} !== {1'b1, oneHot(idx), 2'(b + 1), 1'b0}) begin
          nFail++;
          $display("FAIL next_read b%0d: got rd=%b sel=%h bs=%0d v=%b, expected rd=1 sel=%h bs=%0d v=0", b + 1, rd_en, line_sel, byte_sel, out_valid, oneHot(idx), b + 1);
        end
      end else begin
        if ({req_ready, busy, out_valid, out_last, rd_en, line_sel} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
          nFail++;
          $display("FAIL line_end: got rdy=%b busy=%b v=%b l=%b rd=%b sel=%h, expected 1 0 0 0 0 00", req_ready, busy, out_valid, out_last, rd_en, line_sel);
        end
      end
    end
  endtask

  task automatic test_full_line();
    for (int b = 0; b < LB; b++) mem[5][b] = 8'hA0 + 8'(b);
    do_line(5, -1, 0);
  endtask

  task automatic test_backpressure();
    do_line(5, 1, 4);
  endtask

  task automatic test_back_to_back();
    int hs;
    bit done;
    req_valid = 1'b1; req_index = 3'd0; out_ready = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({rd_en, line_sel} !== {1'b1, 8'h01}) begin
      nFail++;
      $display("FAIL b2b_first: got rd=%b sel=%h, expected 1 01", rd_en, line_sel);
    end
    req_index = 3'd7;
    hs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        nChecks++;
        if (out_data !== mem[0][hs]) begin
          nFail++;
          $display("FAIL b2b_line0 b%0d: got %h expected %h", hs, out_data, mem[0][hs]);
        end
        hs++;
        if (hs == LB) done = 1'b1;
      end
    end
    nChecks++;
    if (!done) begin
      nFail++;
      $display("FAIL b2b_timeout: got %0d handshakes expected %0d", hs, LB);
    end
    @(negedge clk);
    nChecks++;
    if ({req_ready, rd_en} !== 2'b10) begin
      nFail++;
      $display("FAIL b2b_gap: got rdy=%b rd=%b, expected 1 0", req_ready, rd_en);
    end
    @(negedge clk);
    nChecks++;
    if ({rd_en, line_sel, req_ready} !== {1'b1, 8'h80, 1'b0}) begin
      nFail++;
      $display("FAIL b2b_second_accept: got rd=%b sel=%h rdy=%b, expected 1 80 0", rd_en, line_sel, req_ready);
    end
    req_valid = 1'b0;
    hs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rd_en) begin
        nChecks++;
        if (line_sel !== 8'h80) begin
          nFail++;
          $display("FAIL b2b_sel7: got %h expected 80", line_sel);
        end
      end
      if (out_valid && out_ready) begin
        nChecks++;
        if ({out_last, out_data} !== {(hs == LB - 1), mem[7][hs]}) begin
          nFail++;
          $display("FAIL b2b_line7 b%0d: got l=%b d=%h expected l=%b d=%h", hs, out_last, out_data, (hs == LB - 1), mem[7][hs]);
        end
        hs++;
        if (hs == LB) done = 1'b1;
      end
    end
    nChecks++;
    if (!done) begin
      nFail++;
      $display("FAIL b2b_line7_timeout: got %0d handshakes expected %0d", hs, LB);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_index = 3'd6; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    nChecks++;
    if ({out_valid, out_data} !== {1'b1, mem[6][2]}) begin
      nFail++;
      $display("FAIL flush_pre: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, mem[6][2]);
    end
    flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({req_ready, out_valid, out_last, rd_en, busy, out_data} !== {5'b10000, mem[6][2]}) begin
      nFail++;
      $display("FAIL flush_idle: got rdy=%b v=%b l=%b rd=%b busy=%b d=%h, expected 1 0 0 0 0 %h", req_ready, out_valid, out_last, rd_en, busy, out_data, mem[6][2]);
    end
    // Flush must win over a request presented in IDLE.
    req_valid = 1'b1; req_index = 3'd4;
    @(negedge clk);
    nChecks++;
    if ({req_ready, rd_en, busy} !== 3'b100) begin
      nFail++;
      $display("FAIL flush_priority: got rdy=%b rd=%b busy=%b, expected 1 0 0", req_ready, rd_en, busy);
    end
    flush = 1'b0; req_valid = 1'b0;
    do_line(3, -1, 0);
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; req_index = 3'd2; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    nChecks++;
    if ({rd_en, line_sel, out_valid, req_ready, busy, out_data} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      nFail++;
      $display("FAIL async_reset: got rd=%b sel=%h v=%b rdy=%b busy=%b d=%h, expected 0 00 0 1 0 00", rd_en, line_sel, out_valid, req_ready, busy, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_line(2, 2, 3);
  endtask

  task automatic test_random();
    logic [8:0] expQ[$];
    logic [8:0] e;
    logic [7:0] holdData;
    int sent;
    int idx;
    int curIdx;
    bit hold;
    bit done;
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < LB; b++) mem[l][b] = 8'($urandom);
    sent = 0; curIdx = 0; hold = 1'b0; done = 1'b0; holdData = '0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (hold) begin
        nChecks++;
        if ({out_valid, out_data} !== {1'b1, holdData}) begin
          nFail++;
          $display("FAIL rand_hold: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, holdData);
        end
      end
      if (rd_en) begin
        nChecks++;
        if (line_sel !== oneHot(curIdx)) begin
          nFail++;
          $display("FAIL rand_sel: got %h expected %h", line_sel, oneHot(curIdx));
        end
      end
      if (req_ready && sent < 30 && ($urandom % 2 == 0)) begin
        idx = int'($urandom % LINES);
        req_valid = 1'b1; req_index = 3'(idx); curIdx = idx;
        for (int b = 0; b < LB; b++) expQ.push_back({(b == LB - 1), mem[idx][b]});
        sent++;
      end else begin
        req_valid = 1'b0; req_index = 3'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      if (out_valid && out_ready) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL rand_extra: got byte %h with no expected byte", out_data);
        end else begin
          e = expQ.pop_front();
          if ({out_last, out_data} !== e) begin
            nFail++;
            $display("FAIL rand_data: got l=%b d=%h expected l=%b d=%h", out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      hold = out_valid && !out_ready;
      holdData = out_data;
      if (sent == 30 && expQ.size() == 0) done = 1'b1;
    end
    nChecks++;
    if (!done) begin
      nFail++;
      $display("FAIL rand_timeout: got %0d sent %0d pending expected 30 sent 0 pending", sent, expQ.size());
    end
    req_valid = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({req_ready, busy, out_valid} !== 3'b100) begin
      nFail++;
      $display("FAIL rand_end_idle: got rdy=%b busy=%b v=%b expected 1 0 0", req_ready, busy, out_valid);
    end
  endtask

  initial begin
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < LB; b++) mem[l][b] = 8'($urandom);
    test_reset();
    test_full_line();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
